multicycle_control_fsm: RTL and testbench

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Control sequencer for a multicycle MIPS-style datapath.
// Memory wait states are bounded by a watchdog that aborts to ERROR.
module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegisterWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_err
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    EXEC_I    = 4'd8,
    I_WB      = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    ERROR     = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     cur;
  state_t     nxt;
  state_t     dec_nxt;
  logic [7:0] cnt;
  logic [5:0] op_q;
  logic       tmo;

  assign tmo   = (cnt == 8'(TIMEOUT)) && !mem_ready;
  assign state = cur;

  always_comb begin
    dec_nxt = ERROR;
    unique case (1'b1)
      Opcode == OP_R:    dec_nxt = EXEC_R;
      Opcode == OP_LW:   dec_nxt = MEM_ADDR;
      Opcode == OP_SW:   dec_nxt = MEM_ADDR;
      Opcode == OP_SLTI: dec_nxt = EXEC_I;
      Opcode == OP_BEQ:  dec_nxt = BRANCH;
      Opcode == OP_J:    dec_nxt = JUMP;
      default:           dec_nxt = ERROR;
    endcase
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:
        nxt = mem_ready ? DECODE : (tmo ? ERROR : FETCH);
      DECODE:
        nxt = dec_nxt;
      MEM_ADDR:
        nxt = (op_q == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:
        nxt = mem_ready ? MEM_WB : (tmo ? ERROR : MEM_READ);
      MEM_WRITE:
        nxt = mem_ready ? FETCH : (tmo ? ERROR : MEM_WRITE);
      EXEC_R:  nxt = R_WB;
      EXEC_I:  nxt = I_WB;
      default: nxt = FETCH;
    endcase
  end

  // Any state change clears the wait counter; only wait states self-loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur  <= FETCH;
      cnt  <= '0;
      op_q <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        cnt <= '0;
      else if (!mem_ready)
        cnt <= cnt + 8'd1;
      if (cur == DECODE)
        op_q <= Opcode;
    end
  end

  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemToReg      = 1'b0;
    RegDst        = 1'b0;
    RegisterWrite = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 3'b000;
    PCSource      = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    bus_err       = 1'b0;
    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready && rst_n;
        PCWrite = mem_ready && rst_n;
        bus_err = tmo;
      end
      DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = (dec_nxt == ERROR);
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        bus_err = tmo;
      end
      MEM_WB: begin
        RegisterWrite = 1'b1;
        MemToReg      = 1'b1;
        instr_done    = 1'b1;
      end
      // The abort cycle drops the write strobe so memory never commits.
      MEM_WRITE: begin
        IorD       = 1'b1;
        MemWrite   = !tmo;
        instr_done = mem_ready;
        bus_err    = tmo;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
      end
      R_WB: begin
        RegisterWrite = 1'b1;
        RegDst        = 1'b1;
        instr_done    = 1'b1;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 3'b111;
      end
      I_WB: begin
        RegisterWrite = 1'b1;
        instr_done    = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegisterWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       instr_done, illegal_op, bus_err;

  multicycle_control_fsm #(.TIMEOUT(3)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst),
    .RegisterWrite(RegisterWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
  //  MemToReg, RegDst, RegisterWrite, ALUSrcA, ALUSrcB, ALUOp,
  //  PCSource, instr_done, illegal_op, bus_err}
  localparam logic [23:0] F0  = {4'd0,  10'b0001000000, 2'b01, 3'b000, 2'b00, 3'b000};
  localparam logic [23:0] F1  = {4'd0,  10'b1001010000, 2'b01, 3'b000, 2'b00, 3'b000};
  localparam logic [23:0] FT  = {4'd0,  10'b0001000000, 2'b01, 3'b000, 2'b00, 3'b001};
  localparam logic [23:0] DC  = {4'd1,  10'b0000000000, 2'b11, 3'b000, 2'b00, 3'b000};
  localparam logic [23:0] DI  = {4'd1,  10'b0000000000, 2'b11, 3'b000, 2'b00, 3'b010};
  localparam logic [23:0] MA  = {4'd2,  10'b0000000001, 2'b10, 3'b000, 2'b00, 3'b000};
  localparam logic [23:0] MR  = {4'd3,  10'b0011000000, 2'b00, 3'b000, 2'b00, 3'b000};
  localparam logic [23:0] MB  = {4'd4,  10'b0000001010, 2'b00, 3'b000, 2'b00, 3'b100};
  localparam logic [23:0] MW0 = {4'd5,  10'b0010100000, 2'b00, 3'b000, 2'b00, 3'b000};
  localparam logic [23:0] MW1 = {4'd5,  10'b0010100000, 2'b00, 3'b000, 2'b00, 3'b100};
  localparam logic [23:0] MWT = {4'd5,  10'b0010000000, 2'b00, 3'b000, 2'b00, 3'b001};
  localparam logic [23:0] XR  = {4'd6,  10'b0000000001, 2'b00, 3'b010, 2'b00, 3'b000};
  localparam logic [23:0] RW  = {4'd7,  10'b0000000110, 2'b00, 3'b000, 2'b00, 3'b100};
  localparam logic [23:0] XI  = {4'd8,  10'b0000000001, 2'b10, 3'b111, 2'b00, 3'b000};
  localparam logic [23:0] IW  = {4'd9,  10'b0000000010, 2'b00, 3'b000, 2'b00, 3'b100};
  localparam logic [23:0] BR  = {4'd10, 10'b0100000001, 2'b00, 3'b001, 2'b01, 3'b100};
  localparam logic [23:0] JP  = {4'd11, 10'b1000000000, 2'b00, 3'b000, 2'b10, 3'b100};
  localparam logic [23:0] ER  = {4'd12, 10'b0000000000, 2'b00, 3'b000, 2'b00, 3'b000};

  localparam logic [5:0] R   = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SLT = 6'b001010;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    string       nm;
    logic [23:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [23:0] act;
  assign act = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                IRWrite, MemToReg, RegDst, RegisterWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSource, instr_done, illegal_op, bus_err};

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      n_chk++;
      if (act !== x.v) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", x.nm, act, x.v);
      end
    end
  end

  task automatic step(input logic r, input logic [5:0] op,
                      input logic [23:0] e, input string nm);
    exp_t x;
    mem_ready = r;
    Opcode    = op;
    x.nm = nm;
    x.v  = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    Opcode    = '0;
    @(posedge clk);
    #1;
    step(0, R, F0, "reset_fetch");
    step(0, R, F0, "reset_hold");
    rst_n = 1'b1;

    step(1, R, F1, "r_fetch");
    step(1, R, DC, "r_decode");
    step(1, R, XR, "r_exec");
    step(1, R, RW, "r_wb");

    step(1, LW, F1, "lw_fetch");
    step(1, LW, DC, "lw_decode");
    step(1, SW, MA, "lw_addr_opchg");
    step(0, SW, MR, "lw_wait1");
    step(0, SW, MR, "lw_wait2");
    step(1, SW, MR, "lw_read");
    step(1, SW, MB, "lw_wb");

    step(1, SW, F1, "sw_fetch");
    step(1, SW, DC, "sw_decode");
    step(1, LW, MA, "sw_addr_opchg");
    step(1, LW, MW1, "sw_write");

    step(1, SLT, F1, "slti_fetch");
    step(1, SLT, DC, "slti_decode");
    step(1, SLT, XI, "slti_exec");
    step(1, SLT, IW, "slti_wb");

    step(1, BEQ, F1, "beq_fetch");
    step(1, BEQ, DC, "beq_decode");
    step(1, BEQ, BR, "beq_branch");

    step(1, J, F1, "j_fetch");
    step(1, J, DC, "j_decode");
    step(1, J, JP, "j_jump");

    step(1, BAD, F1, "ill_fetch");
    step(1, BAD, DI, "ill_decode");
    step(1, BAD, ER, "ill_error");

    step(0, BEQ, F0, "fwait1_after_err");
    step(0, BEQ, F0, "fwait2");
    step(1, BEQ, F1, "fwait_done");
    step(1, BEQ, DC, "fwait_decode");
    step(1, BEQ, BR, "fwait_branch");

    step(1, SW, F1, "swto_fetch");
    step(1, SW, DC, "swto_decode");
    step(1, SW, MA, "swto_addr");
    step(0, SW, MW0, "swto_wait1");
    step(0, SW, MW0, "swto_wait2");
    step(0, SW, MW0, "swto_wait3");
    step(0, SW, MWT, "swto_buserr");
    step(0, SW, ER, "swto_error");

    step(0, R, F0, "fto_wait1");
    step(0, R, F0, "fto_wait2");
    step(0, R, F0, "fto_wait3");
    step(0, R, FT, "fto_buserr");
    step(0, R, ER, "fto_error");

    step(1, LW, F1, "rst_lw_fetch");
    step(1, LW, DC, "rst_lw_decode");
    step(1, LW, MA, "rst_lw_addr");
    step(1, LW, MR, "rst_lw_read");
    rst_n = 1'b0;
    step(0, LW, F0, "rst_in_memwb");
    step(0, LW, F0, "rst_in_hold");
    rst_n = 1'b1;
    step(1, R, F1, "post_rst_fetch");
    step(1, R, DC, "post_rst_decode");
    step(1, R, XR, "post_rst_exec");
    step(1, R, RW, "post_rst_wb");
    step(0, R, F0, "final_fetch");

    repeat (4) if (sb.size() > 0) @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
